tuning_word_controller: RTL



---
 rtl/tuning_word_controller.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/tuning_word_controller.sv
// DDS tuning-word controller: six active-low buttons nudge the phase-accumulator
// step up or down by coarse/micro/nano amounts. Each button is synchronised and
// debounced. Holding a button auto-repeats. The result saturates at MIN/MAX.

// Per-button 2-flop synchroniser plus consecutive-cycle debounce filter.
module twc_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic pressed_o
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;   // accepted raw level, 1 = released
  logic [CW-1:0] cnt_q;

  // Synchronise, then flip the accepted level only after CYCLES straight cycles of disagreement
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_n_i};
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pressed_o = ~level_q;
endmodule

module tuning_word_controller #(
  parameter int               WIDTH           = 32,
  parameter logic [WIDTH-1:0] RESET_WORD      = WIDTH'(171798),
  parameter logic [WIDTH-1:0] STEP_COARSE     = WIDTH'(858993),
  parameter logic [WIDTH-1:0] STEP_MICRO      = WIDTH'(85899),
  parameter logic [WIDTH-1:0] STEP_NANO       = WIDTH'(85),
  parameter logic [WIDTH-1:0] MIN_WORD        = '0,
  parameter logic [WIDTH-1:0] MAX_WORD        = {WIDTH{1'b1}},
  parameter int               DEBOUNCE_CYCLES = 500000,
  parameter int               REPEAT_DELAY    = 25000000,
  parameter int               REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             switch_add_n,
  input  logic             switch_sub_n,
  input  logic             switch_micro_add_n,
  input  logic             switch_micro_sub_n,
  input  logic             switch_nano_add_n,
  input  logic             switch_nano_sub_n,
  output logic [WIDTH-1:0] step,
  output logic             step_update,
  output logic             at_max,
  output logic             at_min
);
  localparam int NB   = 6;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;
  localparam logic [1:0] S_LOCK   = 2'd3;

  // Bit order: even bits add, odd bits subtract; pairs are coarse, micro, nano
  logic [NB-1:0] btn_n;
  logic [NB-1:0] pressed;

  assign btn_n = {switch_nano_sub_n, switch_nano_add_n, switch_micro_sub_n,
                  switch_micro_add_n, switch_sub_n, switch_add_n};

  for (genvar g = 0; g < NB; g++) begin : g_btn
    twc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .reset     (reset),
      .btn_n_i   (btn_n[g]),
      .pressed_o (pressed[g])
    );
  end

  logic [1:0]       state_q, state_d;
  logic [NB-1:0]    btn_q, btn_d;
  logic [RW-1:0]    rpt_q, rpt_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic             upd_q, max_q, min_q;

  logic             apply_en;
  logic [NB-1:0]    apply_sel;
  logic             one_hot;

  assign one_hot = (pressed != '0) && ((pressed & (pressed - 6'd1)) == '0);

  // Button FSM: first step on press, delayed auto-repeat, lock-out on chords
  always_comb begin
    state_d   = state_q;
    btn_d     = btn_q;
    rpt_d     = rpt_q;
    apply_en  = 1'b0;
    apply_sel = btn_q;
    case (state_q)
      S_IDLE: begin
        if (one_hot) begin
          apply_en  = 1'b1;
          apply_sel = pressed;
          btn_d     = pressed;
          rpt_d     = '0;
          state_d   = S_HOLD;
        end else if (pressed != '0) begin
          state_d = S_LOCK;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (pressed == '0) begin
          state_d = S_IDLE;
        end else if (pressed != btn_q) begin
          state_d = S_LOCK;
        end else if (rpt_q == ((state_q == S_HOLD) ? RD_LAST : RP_LAST)) begin
          apply_en = 1'b1;
          rpt_d    = '0;
          state_d  = S_REPEAT;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
      S_LOCK: begin
        if (pressed == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating add/subtract in WIDTH+1 bits so nothing ever wraps
  logic [WIDTH-1:0] amt;
  logic             is_add;
  logic [WIDTH:0]   sum, room;
  logic [WIDTH-1:0] new_word;

  always_comb begin
    amt = '0;
    if (|apply_sel[1:0]) amt = STEP_COARSE;
    if (|apply_sel[3:2]) amt = STEP_MICRO;
    if (|apply_sel[5:4]) amt = STEP_NANO;
    is_add = |(apply_sel & 6'b010101);
    sum    = {1'b0, step_q} + {1'b0, amt};
    room   = {1'b0, step_q} - {1'b0, MIN_WORD};
    if (is_add) begin
      new_word = (sum > {1'b0, MAX_WORD}) ? MAX_WORD : sum[WIDTH-1:0];
    end else begin
      new_word = (room < {1'b0, amt}) ? MIN_WORD : (step_q - amt);
    end
    step_d = apply_en ? new_word : step_q;
  end

  // State and output registers; flags are derived from the next step so they never lag it
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      btn_q   <= '0;
      rpt_q   <= '0;
      step_q  <= RESET_WORD;
      upd_q   <= 1'b0;
      max_q   <= (RESET_WORD == MAX_WORD);
      min_q   <= (RESET_WORD == MIN_WORD);
    end else begin
      state_q <= state_d;
      btn_q   <= btn_d;
      rpt_q   <= rpt_d;
      step_q  <= step_d;
      upd_q   <= apply_en && (new_word != step_q);
      max_q   <= (step_d == MAX_WORD);
      min_q   <= (step_d == MIN_WORD);
    end
  end

  assign step        = step_q;
  assign step_update = upd_q;
  assign at_max      = max_q;
  assign at_min      = min_q;
endmodule
